// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Divider hardware and DIV/DIVU decoding exist only when MDU_DIV_EN is defined.
module mdu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MduOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] res,
  output logic        dbg_state_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
`ifdef MDU_DIV_EN
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
`endif
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [0:0]  state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;
  logic        wr_q, wr_d;
  logic        busy_q;

  // Both operands are extended to 64 bits so one multiplier serves MULT and MULTU.
  logic [63:0] ext_a, ext_b, prod;
  always_comb begin
    if (MduOp == OP_MULT) begin
      ext_a = {{32{A[31]}}, A};
      ext_b = {{32{B[31]}}, B};
    end else begin
      ext_a = {32'b0, A};
      ext_b = {32'b0, B};
    end
    prod = ext_a * ext_b;
  end

`ifdef MDU_DIV_EN
  logic        b_zero;
  logic [31:0] quo, rem;
  assign b_zero = (B == 32'b0);

  // Signed overflow case is pinned explicitly rather than left to the divider.
  always_comb begin
    quo = 32'b0;
    rem = 32'b0;
    if (!b_zero) begin
      if (MduOp == OP_DIV) begin
        if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          quo = 32'h8000_0000;
          rem = 32'b0;
        end else begin
          quo = $signed(A) / $signed(B);
          rem = $signed(A) % $signed(B);
        end
      end else begin
        quo = A / B;
        rem = A % B;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (MduOp)
            OP_MULT, OP_MULTU: begin
              phi_d   = prod[63:32];
              plo_d   = prod[31:0];
              wr_d    = 1'b1;
              count_d = 4'd5;
              state_d = S_RUN;
            end
`ifdef MDU_DIV_EN
            // Divide by zero still runs the full window but never commits.
            OP_DIV, OP_DIVU: begin
              phi_d   = rem;
              plo_d   = quo;
              wr_d    = !b_zero;
              count_d = 4'd10;
              state_d = S_RUN;
            end
`endif
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      default: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = S_IDLE;
          if (wr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= 4'd0;
      hi_q    <= 32'b0;
      lo_q    <= 32'b0;
      phi_q   <= 32'b0;
      plo_q   <= 32'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      wr_q    <= wr_d;
      busy_q  <= (state_d == S_RUN);
    end
  end

  assign Busy        = busy_q;
  assign dbg_state_o = state_q;

  always_comb begin
    res = 32'b0;
    if (MduOp == OP_MFHI) res = hi_q;
    else if (MduOp == OP_MFLO) res = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: vector table of single operations plus hand-written sequences
// for ignored starts during RUN and reset mid-operation. Honours MDU_DIV_EN.
module tb_mdu;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

`ifdef MDU_DIV_EN
  localparam logic [3:0]  LONG_OP  = OP_DIV;
  localparam logic [31:0] TAB_HI   = 32'd2;
  localparam logic [31:0] TAB_LO   = 32'd14;
`else
  localparam logic [3:0]  LONG_OP  = OP_MULT;
  localparam logic [31:0] TAB_HI   = 32'h1234_5678;
  localparam logic [31:0] TAB_LO   = 32'hCAFE_F00D;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  MduOp = OP_NONE;
  logic        Start = 1'b0;
  logic        Busy;
  logic [31:0] res;
  logic        dbg_state;

  mdu dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .A          (A),
    .B          (B),
    .MduOp      (MduOp),
    .Start      (Start),
    .Busy       (Busy),
    .res        (res),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic read_check();
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    MduOp = OP_MFHI;
    #1 check("mfhi", res, e[63:32]);
    MduOp = OP_MFLO;
    #1 check("mflo", res, e[31:0]);
    MduOp = OP_NONE;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    exp_q.push_back({ehi, elo});
    @(negedge clk);
    MduOp = op; A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MduOp = OP_NONE;
    n = 0;
    while (Busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, exp_busy);
    check("state_idle", {31'b0, dbg_state}, 32'd0);
    read_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic [63:0] p;
    longint sa, sb;

    // Reset state
    #1;
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_state", {31'b0, dbg_state}, 32'd0);
    MduOp = OP_MFHI;
    #1 check("rst_hi", res, 32'd0);
    MduOp = OP_MFLO;
    #1 check("rst_lo", res, 32'd0);
    MduOp = OP_NONE;
    @(negedge clk);
    reset_n = 1'b1;

    // Table of single operations, expected values cumulative from reset.
    vecs.push_back('{OP_MULT,  32'hFFFF_FFFE, 32'd3,         4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'd2,         4'd5, 32'h0000_0001, 32'hFFFF_FFFE});
    vecs.push_back('{OP_MULT,  32'h8000_0000, 32'h8000_0000, 4'd5, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 4'd5, 32'h0000_0001, 32'h0000_0000});
    vecs.push_back('{OP_MTHI,  32'h1234_5678, 32'd0,         4'd0, 32'h1234_5678, 32'h0000_0000});
    vecs.push_back('{OP_MTLO,  32'hCAFE_F00D, 32'd0,         4'd0, 32'h1234_5678, 32'hCAFE_F00D});
    vecs.push_back('{OP_NONE,  32'h1111_1111, 32'd5,         4'd0, 32'h1234_5678, 32'hCAFE_F00D});
    vecs.push_back('{OP_MFHI,  32'h2222_2222, 32'd5,         4'd0, 32'h1234_5678, 32'hCAFE_F00D});
    vecs.push_back('{4'd15,    32'h3333_3333, 32'd5,         4'd0, 32'h1234_5678, 32'hCAFE_F00D});
`ifdef MDU_DIV_EN
    vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'd2,         4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 4'd10, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{OP_DIVU,  32'd100,       32'd7,         4'd10, 32'd2,         32'd14});
    vecs.push_back('{OP_DIVU,  32'd55,        32'd0,         4'd10, 32'd2,         32'd14});
`else
    vecs.push_back('{OP_DIV,   32'd10,        32'd2,         4'd0, 32'h1234_5678, 32'hCAFE_F00D});
    vecs.push_back('{OP_DIVU,  32'd5,         32'd0,         4'd0, 32'h1234_5678, 32'hCAFE_F00D});
`endif
    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, int'(vecs[i].busy), vecs[i].hi, vecs[i].lo);

    // MTHI, then MULT with MTLO attempted at busy cycle 2: MTLO dropped, HI holds until commit.
    run_op(OP_MTHI, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, TAB_LO);
    exp_q.push_back({32'd0, 32'd6});
    @(negedge clk);
    MduOp = OP_MULT; A = 32'd2; B = 32'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MduOp = OP_MFHI; n = 1;
    #1 check("run_c1_busy", {31'b0, Busy}, 32'd1);
    check("run_c1_hi", res, 32'h1234_5678);
    @(negedge clk);
    n = 2;
    check("run_c2_busy", {31'b0, Busy}, 32'd1);
    MduOp = OP_MTLO; A = 32'hDEAD_BEEF; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MduOp = OP_MFHI; n = 3;
    while (Busy && n < 20) begin
      #1 check("run_hi_hold", res, 32'h1234_5678);
      @(negedge clk);
      if (Busy) n++;
    end
    check("run_busy_cycles", n, 32'd5);
    read_check();

    // Reset pulse at busy cycle 4 aborts the operation.
    @(negedge clk);
    MduOp = LONG_OP; A = 32'd100; B = 32'd7; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MduOp = OP_NONE;
    repeat (3) @(negedge clk);
    check("abort_c4_busy", {31'b0, Busy}, 32'd1);
    reset_n = 1'b0;
    #1 check("abort_busy", {31'b0, Busy}, 32'd0);
    check("abort_state", {31'b0, dbg_state}, 32'd0);
    exp_q.push_back({32'd0, 32'd0});
    read_check();
    @(negedge clk);
    reset_n = 1'b1;
    run_op(OP_MULTU, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    // Random multiplies against a 64-bit reference product.
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      p = {32'b0, ra} * {32'b0, rb};
      run_op(OP_MULTU, ra, rb, 5, p[63:32], p[31:0]);
      ra = $urandom; rb = 32'($urandom_range(0, 2000)) - 32'd1000;
      sa = longint'($signed(ra)); sb = longint'($signed(rb));
      p = 64'(sa * sb);
      run_op(OP_MULT, ra, rb, 5, p[63:32], p[31:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have a clk input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have a reset_n input, 1 bit, an asynchronous active-low reset.
REQ-003 The block SHALL have an A input, 32 bits, the rs operand.
REQ-004 The block SHALL have a B input, 32 bits, the rt operand.
REQ-005 The block SHALL have an MduOp input, 4 bits: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; other codes are treated as NONE.
REQ-006 The block SHALL have a Start input, 1 bit, which qualifies MduOp 1-6 for one cycle.
REQ-007 The block SHALL have a Busy output, 1 bit, high while an operation is in flight.
REQ-008 The block SHALL have a res output, 32 bits, the read data for MFHI/MFLO.

Function
REQ-009 The block SHALL implement a two-state FSM, IDLE and RUN, plus a 4-bit down-counter, 32-bit HI and LO, and 32-bit pending registers pHI and pLO.
REQ-010 In IDLE with Start=1 and MduOp MULT/MULTU, the block SHALL latch the signed/unsigned 64-bit product into {pHI,pLO}, load count=5 and enter RUN.
REQ-011 In IDLE with Start=1 and MduOp DIV/DIVU, the block SHALL latch quotient into pLO and remainder into pHI, load count=10 and enter RUN.
REQ-012 Signed division SHALL truncate toward zero, with the remainder taking the dividend's sign; 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-013 For division with B=0, the block SHALL still go busy for 10 cycles, and HI and LO SHALL remain unchanged at completion.
REQ-014 In RUN the counter SHALL decrement each cycle; on the edge where it reaches 0, HI<=pHI and LO<=pLO and the FSM SHALL return to IDLE.
REQ-015 Busy SHALL be a registered output: 1 for exactly 5 (multiply) or 10 (divide) cycles, beginning the cycle after Start, and 0 otherwise.
REQ-016 Start with any MduOp SHALL be ignored while in RUN, with no restart and no HI/LO write.
REQ-017 MTHI/MTLO with Start=1 in IDLE SHALL write A into HI/LO at that edge without going busy.
REQ-018 res SHALL be combinational: HI when MduOp=MFHI, LO when MduOp=MFLO, 0 otherwise; during RUN it returns the pre-operation HI/LO.
REQ-019 Start=1 with MduOp NONE/MFHI/MFLO SHALL cause no state change.

Reset
REQ-020 While reset_n=0, the block SHALL asynchronously hold FSM=IDLE, count=0, Busy=0, and HI, LO, pHI and pLO at 0.
REQ-021 Reset asserted mid-operation SHALL abort the operation with no HI/LO commit; the first Start after release SHALL be accepted normally.

Configuration
REQ-022 With macro MDU_DIV_EN defined, DIV/DIVU SHALL behave per REQ-011 to REQ-013.
REQ-023 With MDU_DIV_EN undefined, no divider logic SHALL be built; DIV/DIVU SHALL be treated as NONE, with Busy staying 0 and HI/LO unchanged.

Verification
REQ-024 The bench SHALL cover: MULT A=0xFFFFFFFE, B=3 -> Busy high for cycles 1-5; after that, MFHI=0xFFFFFFFF and MFLO=0xFFFFFFFA.
REQ-025 The bench SHALL cover: MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-026 The bench SHALL cover: DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles, LO=0xFFFFFFFD and HI=0xFFFFFFFF; DIVU with B=0 -> HI/LO unchanged.
REQ-027 The bench SHALL cover: MTHI A=0x12345678 then MULT started, with MTLO issued at busy cycle 2 -> MTLO ignored, and MFHI reads 0x12345678 until the commit.
REQ-028 The bench SHALL cover: DIV started, with reset_n pulsed low at busy cycle 4 -> Busy=0 immediately, HI=LO=0, and a following MULTU 3x4 gives LO=12.
REQ-029 The bench SHALL cover: a build without MDU_DIV_EN, issuing DIV A=10, B=2 -> Busy stays 0 and LO unchanged.
